// File: rtl/rf_access_ctrl_pkg.sv
// rtl/rf_access_ctrl_pkg.sv - shared widths and FSM encoding for the register-file access controller
// Contents:
//   DEF_DATA_W / DEF_ADDR_W : default register data width and index width
//   state_t                 : sequencer states (idle, write, read setup, read capture, clear)
package rf_access_ctrl_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WR       = 3'd1,
    ST_RD_SETUP = 3'd2,
    ST_RD_CAPT  = 3'd3,
    ST_CLR      = 3'd4
  } state_t;

endpackage

// File: rtl/rf_access_ctrl_if.sv
// rtl/rf_access_ctrl_if.sv - bus bundle between the core, the access controller and the register file
// Signals:
//   rd_req_valid/ready, rd_rs1/rd_rs2 : operand read request
//   op_valid/ready, op1/op2           : returned operand pair
//   wb_valid/ready, wb_rd/wb_data     : writeback request
//   clr_req                           : clear-whole-file pulse
//   rf_rst, rf_we, rf_i1, rf_i2, rf_y : controls to the register file
//   rf_x1, rf_x2                      : read data from the register file
// Modports: master = core and register-file side, slave = controller.
interface rf_access_ctrl_if
  import rf_access_ctrl_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
);

  logic              rd_req_valid;
  logic              rd_req_ready;
  logic [ADDR_W-1:0] rd_rs1;
  logic [ADDR_W-1:0] rd_rs2;
  logic              op_valid;
  logic              op_ready;
  logic [DATA_W-1:0] op1;
  logic [DATA_W-1:0] op2;
  logic              wb_valid;
  logic              wb_ready;
  logic [ADDR_W-1:0] wb_rd;
  logic [DATA_W-1:0] wb_data;
  logic              clr_req;
  logic              rf_rst;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_i1;
  logic [ADDR_W-1:0] rf_i2;
  logic [DATA_W-1:0] rf_y;
  logic [DATA_W-1:0] rf_x1;
  logic [DATA_W-1:0] rf_x2;

  modport master (
    output rd_req_valid, rd_rs1, rd_rs2, op_ready, wb_valid, wb_rd, wb_data, clr_req,
           rf_x1, rf_x2,
    input  rd_req_ready, op_valid, op1, op2, wb_ready, rf_rst, rf_we, rf_i1, rf_i2, rf_y
  );

  modport slave (
    input  rd_req_valid, rd_rs1, rd_rs2, op_ready, wb_valid, wb_rd, wb_data, clr_req,
           rf_x1, rf_x2,
    output rd_req_ready, op_valid, op1, op2, wb_ready, rf_rst, rf_we, rf_i1, rf_i2, rf_y
  );

endinterface

// File: rtl/rf_wb_buffer.sv
// rtl/rf_wb_buffer.sv - one-entry writeback buffer with two-index forwarding compare
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   load, load_rd/data  : capture a writeback (only issued while empty)
//   drain               : release the entry (issued in the write cycle)
//   cmp_a, cmp_b        : operand indices to compare against the held destination
//   full, buf_rd/data   : entry state and contents
//   hit_a, hit_b        : entry is full and matches cmp_a / cmp_b
module rf_wb_buffer
  import rf_access_ctrl_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_rd,
  input  logic [DATA_W-1:0] load_data,
  input  logic              drain,
  input  logic [ADDR_W-1:0] cmp_a,
  input  logic [ADDR_W-1:0] cmp_b,
  output logic              full,
  output logic [ADDR_W-1:0] buf_rd,
  output logic [DATA_W-1:0] buf_data,
  output logic              hit_a,
  output logic              hit_b
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full     <= 1'b0;
      buf_rd   <= '0;
      buf_data <= '0;
    end else if (load) begin
      full     <= 1'b1;
      buf_rd   <= load_rd;
      buf_data <= load_data;
    end else if (drain) begin
      full <= 1'b0;
    end
  end

  assign hit_a = full && (buf_rd == cmp_a);
  assign hit_b = full && (buf_rd == cmp_b);

endmodule

// File: rtl/rf_access_ctrl.sv
// rtl/rf_access_ctrl.sv - serialises operand reads, writebacks and clears onto the register file
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset (also holds rf_rst high to clear the file)
//   bus  : rf_access_ctrl_if.slave - read request, operand return, writeback,
//          clear request and the registered register-file control/data signals
module rf_access_ctrl
  import rf_access_ctrl_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input logic           clk,
  input logic           rst,
  rf_access_ctrl_if.slave bus
);

  state_t state, next_state;

  logic              buf_full;
  logic [ADDR_W-1:0] buf_rd;
  logic [DATA_W-1:0] buf_data;
  logic              hit1, hit2;

  logic [ADDR_W-1:0] rs1_q, rs2_q;
  logic              clr_pending;
  logic              op_valid_q;
  logic [DATA_W-1:0] op1_q, op2_q;

  logic              rf_rst_q, rf_we_q;
  logic [ADDR_W-1:0] rf_i1_q, rf_i2_q;
  logic [DATA_W-1:0] rf_y_q;
  logic              rf_rst_d, rf_we_d;
  logic [ADDR_W-1:0] rf_i1_d, rf_i2_d;
  logic [DATA_W-1:0] rf_y_d;

  logic rd_ready, rd_hs, wb_hs;

  assign rd_ready = (state == ST_IDLE) && !buf_full && !op_valid_q && !clr_pending;
  assign rd_hs    = bus.rd_req_valid && rd_ready;
  assign wb_hs    = bus.wb_valid && !buf_full;

  rf_wb_buffer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_wb_buffer (
    .clk       (clk),
    .rst       (rst),
    .load      (wb_hs),
    .load_rd   (bus.wb_rd),
    .load_data (bus.wb_data),
    .drain     (state == ST_WR),
    .cmp_a     (rs1_q),
    .cmp_b     (rs2_q),
    .full      (buf_full),
    .buf_rd    (buf_rd),
    .buf_data  (buf_data),
    .hit_a     (hit1),
    .hit_b     (hit2)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      rf_rst_q <= 1'b1;
      rf_we_q  <= 1'b0;
      rf_i1_q  <= '0;
      rf_i2_q  <= '0;
      rf_y_q   <= '0;
    end else begin
      state    <= next_state;
      rf_rst_q <= rf_rst_d;
      rf_we_q  <= rf_we_d;
      rf_i1_q  <= rf_i1_d;
      rf_i2_q  <= rf_i2_d;
      rf_y_q   <= rf_y_d;
    end
  end

  // The register-file controls are computed for the state being entered so
  // they come straight out of flops during that state. Indices and write data
  // hold their last value otherwise, keeping them stable through RD_CAPT.
  always_comb begin
    next_state = state;
    rf_rst_d   = 1'b0;
    rf_we_d    = 1'b0;
    rf_i1_d    = rf_i1_q;
    rf_i2_d    = rf_i2_q;
    rf_y_d     = rf_y_q;
    case (state)
      ST_IDLE: begin
        if (clr_pending && !buf_full) next_state = ST_CLR;
        else if (buf_full)            next_state = ST_WR;
        else if (rd_hs)               next_state = ST_RD_SETUP;
      end
      ST_WR:       next_state = ST_IDLE;
      ST_RD_SETUP: next_state = ST_RD_CAPT;
      ST_RD_CAPT:  next_state = ST_IDLE;
      ST_CLR:      next_state = ST_IDLE;
      default:     next_state = ST_IDLE;
    endcase
    case (next_state)
      ST_WR: begin
        rf_we_d = 1'b1;
        rf_i2_d = buf_rd;
        rf_y_d  = buf_data;
      end
      ST_RD_SETUP: begin
        // Entered only from the handshake cycle, so the request indices are live.
        rf_i1_d = bus.rd_rs1;
        rf_i2_d = bus.rd_rs2;
      end
      ST_CLR:  rf_rst_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rs1_q <= '0;
      rs2_q <= '0;
    end else if (rd_hs) begin
      rs1_q <= bus.rd_rs1;
      rs2_q <= bus.rd_rs2;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  clr_pending <= 1'b0;
    else if (bus.clr_req)     clr_pending <= 1'b1;
    else if (state == ST_CLR) clr_pending <= 1'b0;
  end

  // A write still sitting in the buffer is newer than the file contents, so
  // it overrides the sampled value per operand.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_valid_q <= 1'b0;
      op1_q      <= '0;
      op2_q      <= '0;
    end else if (state == ST_RD_CAPT) begin
      op_valid_q <= 1'b1;
      op1_q      <= hit1 ? buf_data : bus.rf_x1;
      op2_q      <= hit2 ? buf_data : bus.rf_x2;
    end else if (op_valid_q && bus.op_ready) begin
      op_valid_q <= 1'b0;
    end
  end

  assign bus.rd_req_ready = rd_ready;
  assign bus.wb_ready     = !buf_full;
  assign bus.op_valid     = op_valid_q;
  assign bus.op1          = op1_q;
  assign bus.op2          = op2_q;
  assign bus.rf_rst       = rf_rst_q;
  assign bus.rf_we        = rf_we_q;
  assign bus.rf_i1        = rf_i1_q;
  assign bus.rf_i2        = rf_i2_q;
  assign bus.rf_y         = rf_y_q;

endmodule

// File: tb/tb_rf_access_ctrl.sv
// tb/tb_rf_access_ctrl.sv - self-checking bench for rf_access_ctrl with a register-file model
module tb_rf_access_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  rf_access_ctrl_if bus ();

  rf_access_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Physical 16x32 register file driven by the controller outputs.
  logic [31:0] mem [16];
  always @(posedge clk) begin
    if (bus.rf_rst) begin
      for (int i = 0; i < 16; i++) mem[i] <= '0;
    end else if (bus.rf_we) begin
      mem[bus.rf_i2] <= bus.rf_y;
    end
  end
  assign bus.rf_x1 = mem[bus.rf_i1];
  assign bus.rf_x2 = mem[bus.rf_i2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Architectural model: writes take effect when accepted, a clear wipes
  // everything accepted so far, and a read accepted in cycle T sees every
  // write accepted up to T+1 and presents its pair from T+3 until consumed.
  logic [31:0] arch [16];
  bit          model_ov = 1'b0;
  int          snap_stage = 0;
  logic [3:0]  m_rs1, m_rs2;
  logic [31:0] snap1, snap2, exp1, exp2;
  int          we_cnt = 0, we_cyc = 0, rrst_cnt = 0, rrst_cyc = 0;
  logic [3:0]  we_idx = '0;
  logic [31:0] we_dat = '0;

  always @(negedge clk) begin
    if (rst) begin
      model_ov   = 1'b0;
      snap_stage = 0;
      for (int i = 0; i < 16; i++) arch[i] = '0;
    end else begin
      chk("op_valid", bus.op_valid, model_ov);
      if (model_ov) begin
        chk("op1", bus.op1, exp1);
        chk("op2", bus.op2, exp2);
      end
      chk("we_rst_excl", bus.rf_we & bus.rf_rst, 0);
      if (bus.rf_we) begin
        we_cnt++; we_cyc = cyc; we_idx = bus.rf_i2; we_dat = bus.rf_y;
      end
      if (bus.rf_rst) begin
        rrst_cnt++; rrst_cyc = cyc;
      end
      if (model_ov && bus.op_ready) model_ov = 1'b0;
      if (snap_stage == 2) begin
        model_ov = 1'b1; exp1 = snap1; exp2 = snap2; snap_stage = 0;
      end
      if (bus.wb_valid && bus.wb_ready) arch[bus.wb_rd] = bus.wb_data;
      if (snap_stage == 1) begin
        snap1 = arch[m_rs1]; snap2 = arch[m_rs2]; snap_stage = 2;
      end
      if (bus.rd_req_valid && bus.rd_req_ready) begin
        m_rs1 = bus.rd_rs1; m_rs2 = bus.rd_rs2; snap_stage = 1;
      end
      if (bus.clr_req) for (int i = 0; i < 16; i++) arch[i] = '0;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_wb(input logic [3:0] rd, input logic [31:0] d, output int at);
    bit done = 1'b0;
    at = -1;
    bus.wb_valid = 1'b1; bus.wb_rd = rd; bus.wb_data = d;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      if (bus.wb_ready) begin done = 1'b1; at = cyc; end
      @(posedge clk); #1;
    end
    bus.wb_valid = 1'b0;
    chk("wb_accept", done, 1);
  endtask

  task automatic send_rd(input logic [3:0] rs1, input logic [3:0] rs2, output int at);
    bit done = 1'b0;
    at = -1;
    bus.rd_req_valid = 1'b1; bus.rd_rs1 = rs1; bus.rd_rs2 = rs2;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      if (bus.rd_req_ready) begin done = 1'b1; at = cyc; end
      @(posedge clk); #1;
    end
    bus.rd_req_valid = 1'b0;
    chk("rd_accept", done, 1);
  endtask

  task automatic check_op(input int acc, input logic [31:0] e1, input logic [31:0] e2,
                          input string tag);
    @(negedge clk);
    while (cyc < acc + 3) @(negedge clk);
    chk({tag, "_valid"}, bus.op_valid, 1);
    chk({tag, "_op1"}, bus.op1, e1);
    chk({tag, "_op2"}, bus.op2, e2);
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int acc, acc2;
    bus.rd_req_valid = 1'b0; bus.rd_rs1 = '0; bus.rd_rs2 = '0;
    bus.op_ready = 1'b1; bus.wb_valid = 1'b0; bus.wb_rd = '0; bus.wb_data = '0;
    bus.clr_req = 1'b0;
    rst = 1'b1;

    // Reset state and release
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rf_rst", bus.rf_rst, 1);
    chk("rst_rf_we", bus.rf_we, 0);
    chk("rst_op_valid", bus.op_valid, 0);
    chk("rst_op1", bus.op1, 0);
    chk("rst_rf_i2", bus.rf_i2, 0);
    chk("rst_rf_y", bus.rf_y, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rf_rst_after_fall", bus.rf_rst, 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rf_rst_released", bus.rf_rst, 0);
    chk("idle_rd_ready", bus.rd_req_ready, 1);
    chk("idle_wb_ready", bus.wb_ready, 1);
    chk("idle_op_valid", bus.op_valid, 0);
    @(posedge clk); #1;

    // Write r3, then read r3/r0
    send_wb(4'd3, 32'hDEADBEEF, acc);
    idle(4);
    chk("t2_we_cnt", we_cnt, 1);
    chk("t2_we_idx", we_idx, 3);
    chk("t2_we_dat", we_dat, 32'hDEADBEEF);
    send_rd(4'd3, 4'd0, acc);
    @(negedge clk); chk("t2_lat_t1", bus.op_valid, 0);
    @(negedge clk); chk("t2_lat_t2", bus.op_valid, 0);
    check_op(acc, 32'hDEADBEEF, 32'h0, "t2");

    // Same-cycle write r5 and read r5/r5: forwarded, write lands afterwards
    bus.wb_valid = 1'b1; bus.wb_rd = 4'd5; bus.wb_data = 32'h12345678;
    bus.rd_req_valid = 1'b1; bus.rd_rs1 = 4'd5; bus.rd_rs2 = 4'd5;
    @(negedge clk);
    chk("t3_both_ready", {bus.rd_req_ready, bus.wb_ready}, 2'b11);
    acc = cyc;
    @(posedge clk); #1;
    bus.wb_valid = 1'b0; bus.rd_req_valid = 1'b0;
    check_op(acc, 32'h12345678, 32'h12345678, "t3");
    idle(3);
    chk("t3_we_idx", we_idx, 5);
    chk("t3_we_dat", we_dat, 32'h12345678);
    chk("t3_we_after_op", we_cyc > acc + 3, 1);

    // Write accepted in RD_SETUP is observed
    send_wb(4'd7, 32'd9, acc2);
    idle(4);
    send_rd(4'd7, 4'd3, acc);
    send_wb(4'd7, 32'd1, acc2);
    chk("t4a_wb_in_setup", acc2, acc + 1);
    check_op(acc, 32'd1, 32'hDEADBEEF, "t4a");
    idle(4);

    // Write accepted in RD_CAPT is not observed
    send_wb(4'd7, 32'd9, acc2);
    idle(4);
    send_rd(4'd7, 4'd3, acc);
    @(posedge clk); #1;
    send_wb(4'd7, 32'd1, acc2);
    chk("t4b_wb_in_capt", acc2, acc + 2);
    check_op(acc, 32'd9, 32'hDEADBEEF, "t4b");
    idle(4);

    // Back-pressure on the operand pair
    bus.op_ready = 1'b0;
    send_rd(4'd3, 4'd7, acc);
    check_op(acc, 32'hDEADBEEF, 32'd1, "t5");
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t5_hold_valid", bus.op_valid, 1);
      chk("t5_hold_op1", bus.op1, 32'hDEADBEEF);
      chk("t5_hold_op2", bus.op2, 32'd1);
      chk("t5_hold_rd_ready", bus.rd_req_ready, 0);
      @(posedge clk); #1;
    end
    bus.op_ready = 1'b1;
    @(negedge clk);
    chk("t5_release_valid", bus.op_valid, 1);
    chk("t5_release_rd_ready", bus.rd_req_ready, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t5_after_valid", bus.op_valid, 0);
    chk("t5_after_rd_ready", bus.rd_req_ready, 1);
    @(posedge clk); #1;

    // Clear with r2 buffered: write first, then one rf_rst cycle
    rrst_cnt = 0;
    send_wb(4'd2, 32'hAA, acc);
    bus.clr_req = 1'b1;
    @(posedge clk); #1;
    bus.clr_req = 1'b0;
    idle(6);
    chk("t6_we_idx", we_idx, 2);
    chk("t6_we_dat", we_dat, 32'hAA);
    chk("t6_rrst_cnt", rrst_cnt, 1);
    chk("t6_wr_before_clr", we_cyc < rrst_cyc, 1);
    send_rd(4'd2, 4'd3, acc);
    check_op(acc, 32'h0, 32'h0, "t6");

    // Reset during the write cycle
    send_wb(4'd4, 32'h55, acc);
    @(posedge clk); #1;
    chk("t7_we_in_wr", bus.rf_we, 1);
    chk("t7_wr_idx", bus.rf_i2, 4);
    rst = 1'b1;
    #1;
    chk("t7_we_async_drop", bus.rf_we, 0);
    chk("t7_wb_ready", bus.wb_ready, 1);
    chk("t7_rf_rst", bus.rf_rst, 1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    idle(2);
    send_rd(4'd4, 4'd2, acc);
    check_op(acc, 32'h0, 32'h0, "t7");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
